vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FB_W, default 160, framebuffer width in words.
REQ-002 SHALL have parameter FB_H, default 120, framebuffer height in words.
REQ-003 SHALL have parameter SCALE_SH, default 2, screen-to-framebuffer shift; 4x4 screen pixels map to one word.
REQ-004 SHALL have parameter DW, default 8, pixel data width.
REQ-005 SHALL have port i_clk, input, 1, 100 MHz system clock; the only clock.
REQ-006 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port i_pix_stb, input, 1, 25 MHz pixel strobe; one i_clk cycle high in every four.
REQ-008 SHALL have port i_active, input, 1, timing generator active-area flag.
REQ-009 SHALL have ports i_x and i_y, input, 10 each, current screen pixel coordinates.
REQ-010 SHALL have port i_blank_only, input, 1; when 1, writes commit only outside the active area.
REQ-011 SHALL have ports i_wr_valid (1), i_wr_addr (15) and i_wr_data (DW), input, writer request.
REQ-012 SHALL have port o_wr_ready, output, 1, holding register empty.
REQ-013 SHALL have port o_wr_done, output, 1, one-cycle pulse when a write reaches memory.
REQ-014 SHALL have port o_wr_err, output, 1, one-cycle pulse when an out-of-range write is dropped.
REQ-015 SHALL have ports o_mem_en (1), o_mem_we (1), o_mem_addr (15) and o_mem_wdata (DW), output, single-port BRAM control.
REQ-016 SHALL have port i_mem_rdata, input, DW, BRAM read data with 1-cycle latency.
REQ-017 SHALL have port o_pix_data, output, DW, display pixel value.

Function
REQ-018 Display slot: cycle N with i_pix_stb=1 SHALL be reserved for display; drive o_mem_en=1, o_mem_we=0, o_mem_addr=(i_y>>SCALE_SH)*FB_W+(i_x>>SCALE_SH), as shift-add on 15 bits, max 19199.
REQ-019 The display read SHALL be issued whether or not i_active=1; i_active SHALL be registered alongside it.
REQ-020 In cycle N+1, o_pix_data SHALL load i_mem_rdata if the registered active flag is 1, otherwise 0; it is valid from N+2 and held until the next update, a fixed 2-cycle latency.
REQ-021 Write handshake: a transfer SHALL occur when i_wr_valid and o_wr_ready are both 1; addr and data SHALL be latched into a 1-entry holding register.
REQ-022 o_wr_ready SHALL equal the registered inverse of the holding-full flag; no accept and commit in the same cycle.
REQ-023 Range check at accept: if i_wr_addr >= FB_W*FB_H, the write SHALL NOT be held; pulse o_wr_err in the next cycle; o_wr_ready stays 1.
REQ-024 Commit: in any cycle with holding full, i_pix_stb=0, and (i_blank_only=0 or i_active=0), drive o_mem_en=1, o_mem_we=1 and the held addr/data.
REQ-025 On commit, the holding register SHALL be cleared and o_wr_done pulsed in the next cycle.
REQ-026 A commit in cycle N+1 after a display read SHALL be allowed (read-first BRAM); o_pix_data still captures the cycle-N read.
REQ-027 When i_pix_stb=1 and holding is full, the display SHALL win; the write SHALL wait, at most 1 cycle when i_blank_only=0.
REQ-028 With i_blank_only=1 and i_active=1, the write SHALL wait indefinitely with o_wr_ready=0; it commits on the first qualifying cycle.
REQ-029 Idle cycles SHALL drive o_mem_en=0, o_mem_we=0, and hold o_mem_addr and o_mem_wdata at their last values.
REQ-030 Peak write throughput SHALL be one write per 2 cycles.

Reset
REQ-031 With i_rst=1 at a clock edge: holding register SHALL be empty; o_wr_ready=1 from the next cycle; o_wr_done=0, o_wr_err=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_pix_data=0; the registered active flag SHALL be 0.
REQ-032 Reset SHALL take priority over an in-progress commit or display capture; a held write SHALL be discarded without o_wr_done.

Verification
REQ-033 Display fetch: i_pix_stb=1, i_active=1, i_x=17, i_y=9, rdata=0xA5 at N+1 -> o_mem_addr=324 at N; o_pix_data=0xA5 at N+2.
REQ-034 Blank fetch: i_pix_stb=1, i_active=0 -> o_pix_data=0 at N+2; o_mem_en=1 at N.
REQ-035 Collision: write held, i_pix_stb=1 at N, i_blank_only=0 -> N is a read; write at N+1 (addr/data match); o_wr_done at N+2; o_wr_ready=1 at N+2.
REQ-036 Blank-only: i_blank_only=1, write 0x3C to 100 during active -> no o_mem_we until i_active falls; then one commit and o_wr_done.
REQ-037 Range error: write addr 19200 -> o_wr_err pulse; no o_mem_we; o_wr_ready stays 1.
REQ-038 Reset mid-op: write held, i_blank_only=1, i_active=1, i_rst=1 -> no o_wr_done; o_wr_ready=1 after reset; all outputs 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: one display read per pixel strobe and a one-entry write
// holding register that commits into the free cycles between display reads.
module vram_arbiter #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2,
  parameter int DW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_stb,
  input  logic          i_active,
  input  logic [9:0]    i_x,
  input  logic [9:0]    i_y,
  input  logic          i_blank_only,
  input  logic          i_wr_valid,
  input  logic [14:0]   i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ready,
  output logic          o_wr_done,
  output logic          o_wr_err,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [14:0]   o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [DW-1:0] o_pix_data
);

  localparam logic [15:0] FB_WORDS = 16'(FB_W * FB_H);

  logic          full_q, full_d;
  logic [14:0]   hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rd_q, rd_d;
  logic          act_q, act_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [14:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [14:0]   fb_row, fb_col, disp_addr;
  logic          disp, commit, accept, in_range;

  assign fb_row    = 15'(i_y >> SCALE_SH);
  assign fb_col    = 15'(i_x >> SCALE_SH);
  assign disp_addr = fb_row * 15'(FB_W) + fb_col;

  always_comb begin
    // Display owns every strobe cycle; a held write takes any other cycle the blanking rule allows.
    disp     = i_pix_stb && !i_rst;
    commit   = full_q && !i_pix_stb && (!i_blank_only || !i_active) && !i_rst;
    accept   = i_wr_valid && ready_q;
    in_range = {1'b0, i_wr_addr} < FB_WORDS;

    full_d      = full_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    act_d       = act_q;
    pix_d       = pix_q;
    rd_d        = disp;
    done_d      = commit;
    err_d       = accept && !in_range;

    if (disp) begin
      mem_addr_d = disp_addr;
      act_d      = i_active;
    end else if (commit) begin
      mem_addr_d  = hold_addr_q;
      mem_wdata_d = hold_data_q;
    end

    // accept only happens while empty, so it can never coincide with a commit
    if (commit) begin
      full_d = 1'b0;
    end else if (accept && in_range) begin
      full_d      = 1'b1;
      hold_addr_d = i_wr_addr;
      hold_data_d = i_wr_data;
    end
    ready_d = !full_d;

    if (rd_q) begin
      pix_d = act_q ? i_mem_rdata : '0;
    end

    o_mem_en    = disp || commit;
    o_mem_we    = commit;
    o_mem_addr  = mem_addr_d;
    o_mem_wdata = mem_wdata_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      act_q       <= 1'b0;
      pix_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      full_q      <= full_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      act_q       <= act_d;
      pix_q       <= pix_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_wr_ready = ready_q;
  assign o_wr_done  = done_q;
  assign o_wr_err   = err_q;
  assign o_pix_data = pix_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: driver pushes expected writes/errors, a negedge monitor
// checks the memory port, handshake pulses and display pixels against a framebuffer model.
module tb_vram_arbiter;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int NWORDS = FB_W * FB_H;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_pix_stb = 1'b0, i_active = 1'b0, i_blank_only = 1'b0;
  logic [9:0]  i_x = '0, i_y = '0;
  logic        i_wr_valid = 1'b0;
  logic [14:0] i_wr_addr = '0;
  logic [7:0]  i_wr_data = '0;
  logic        o_wr_ready, o_wr_done, o_wr_err, o_mem_en, o_mem_we;
  logic [14:0] o_mem_addr;
  logic [7:0]  o_mem_wdata, o_pix_data;
  logic [7:0]  rdata_q = '0;

  always #5 clk = ~clk;

  vram_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .SCALE_SH(2), .DW(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_active(i_active),
    .i_x(i_x), .i_y(i_y), .i_blank_only(i_blank_only),
    .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .o_wr_done(o_wr_done), .o_wr_err(o_wr_err),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(rdata_q), .o_pix_data(o_pix_data)
  );

  // Read-first single-port BRAM with one cycle of read latency
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
      else          rdata_q <= ram[o_mem_addr];
    end
  end

  typedef struct { int cyc; logic [14:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int due; logic [7:0] val; } pix_t;
  wr_t  wq[$];
  int   errq[$];
  pix_t pixq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_done_cyc = -10;
  logic [7:0]  exp_pix = '0;
  logic [14:0] last_addr = '0;
  logic        post_rst = 1'b0;
  logic        m_full, m_qual, m_err;
  logic [14:0] m_ea;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i_rst) begin
      wq.delete(); errq.delete(); pixq.delete();
      exp_pix = '0; last_addr = '0; exp_done_cyc = -10; post_rst = 1'b1;
    end else begin
      m_full = (wq.size() > 0) && (wq[0].cyc < cyc);
      m_qual = m_full && !i_pix_stb && (!i_blank_only || !i_active);
      m_ea   = 15'((int'(i_y) / 4) * FB_W + int'(i_x) / 4);
      chk("ready", 32'(o_wr_ready), 32'(!m_full));
      if (i_pix_stb) begin
        chk("rd_en", 32'(o_mem_en), 32'd1);
        chk("rd_we", 32'(o_mem_we), 32'd0);
        chk("rd_addr", 32'(o_mem_addr), 32'(m_ea));
        pixq.push_back('{cyc + 2, i_active ? ram[m_ea] : 8'h00});
        last_addr = m_ea;
      end else if (m_qual) begin
        chk("wr_en", 32'(o_mem_en), 32'd1);
        chk("wr_we", 32'(o_mem_we), 32'd1);
        chk("wr_addr", 32'(o_mem_addr), 32'(wq[0].addr));
        chk("wr_data", 32'(o_mem_wdata), 32'(wq[0].data));
        last_addr = wq[0].addr;
        void'(wq.pop_front());
        exp_done_cyc = cyc + 1;
      end else begin
        chk("idle_en", 32'(o_mem_en), 32'd0);
        chk("idle_we", 32'(o_mem_we), 32'd0);
        chk("idle_addr", 32'(o_mem_addr), 32'(last_addr));
        if (post_rst) chk("rst_wdata", 32'(o_mem_wdata), 32'd0);
      end
      chk("done", 32'(o_wr_done), 32'(cyc == exp_done_cyc));
      m_err = (errq.size() > 0) && (errq[0] == cyc - 1);
      chk("err", 32'(o_wr_err), 32'(m_err));
      if (m_err) void'(errq.pop_front());
      if (pixq.size() > 0 && pixq[0].due == cyc) begin
        exp_pix = pixq[0].val;
        void'(pixq.pop_front());
      end
      chk("pix", 32'(o_pix_data), 32'(exp_pix));
      post_rst = 1'b0;
    end
  end

  task automatic drive(input logic rst, input logic stb, input logic act, input logic blank,
                       input logic [9:0] x, input logic [9:0] y,
                       input logic v, input logic [14:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    i_rst = rst; i_pix_stb = stb; i_active = act; i_blank_only = blank;
    i_x = x; i_y = y; i_wr_valid = v; i_wr_addr = a; i_wr_data = d;
    if (!rst && v && o_wr_ready) begin
      if (int'(a) >= NWORDS) errq.push_back(cyc);
      else                   wq.push_back('{cyc, a, d});
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  logic act_r, blank_r;
  int   r;
  logic [14:0] ra;

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'(i * 7 + 3);
    ram[324] = 8'hA5;
    repeat (3) drive(1, 0, 0, 0, '0, '0, 0, '0, '0);
    idle();

    // display fetch of an active pixel
    drive(0, 1, 1, 0, 10'd17, 10'd9, 0, '0, '0);
    @(negedge clk) chk("d_fetch_addr", 32'(o_mem_addr), 32'd324);
    idle(); idle();
    @(negedge clk) chk("d_fetch_pix", 32'(o_pix_data), 32'hA5);

    // blanked fetch still reads but returns zero
    drive(0, 1, 0, 0, 10'd100, 10'd50, 0, '0, '0);
    @(negedge clk) chk("d_blank_en", 32'(o_mem_en), 32'd1);
    idle(); idle();
    @(negedge clk) chk("d_blank_pix", 32'(o_pix_data), 32'd0);

    // collision: display wins, write follows one cycle later
    drive(0, 0, 0, 0, '0, '0, 1, 15'd500, 8'h11);
    drive(0, 1, 1, 0, 10'd40, 10'd40, 0, '0, '0);
    @(negedge clk) chk("d_coll_rd", 32'(o_mem_we), 32'd0);
    idle();
    @(negedge clk) chk("d_coll_wr", 32'({o_mem_we, o_mem_addr, o_mem_wdata}), 32'({1'b1, 15'd500, 8'h11}));
    idle();
    @(negedge clk) chk("d_coll_done", 32'({o_wr_done, o_wr_ready}), 32'b11);

    // blank-only write waits for active to fall
    drive(0, 0, 1, 1, '0, '0, 1, 15'd100, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      drive(0, (i % 4) == 0, 1, 1, 10'd8, 10'd8, 0, '0, '0);
      @(negedge clk) chk("d_blank_hold", 32'({o_mem_we, o_wr_ready}), 32'd0);
    end
    drive(0, 0, 0, 1, '0, '0, 0, '0, '0);
    @(negedge clk) chk("d_blank_wr", 32'({o_mem_we, o_mem_addr, o_mem_wdata}), 32'({1'b1, 15'd100, 8'h3C}));
    idle();
    @(negedge clk) chk("d_blank_done", 32'(o_wr_done), 32'd1);

    // range boundary
    drive(0, 0, 0, 0, '0, '0, 1, 15'd19200, 8'h99);
    idle();
    @(negedge clk) chk("d_range_err", 32'({o_wr_err, o_wr_ready, o_mem_we}), 32'b110);
    drive(0, 0, 0, 0, '0, '0, 1, 15'd19199, 8'h42);
    idle();
    @(negedge clk) chk("d_range_last", 32'({o_mem_we, o_mem_addr}), 32'({1'b1, 15'd19199}));
    idle(); idle();

    // reset while a blank-only write is pending
    drive(0, 0, 1, 1, '0, '0, 1, 15'd200, 8'h77);
    drive(0, 0, 1, 1, '0, '0, 0, '0, '0);
    drive(0, 0, 1, 1, '0, '0, 0, '0, '0);
    drive(1, 0, 1, 1, '0, '0, 0, '0, '0);
    idle();
    @(negedge clk) begin
      chk("d_rst_ready", 32'(o_wr_ready), 32'd1);
      chk("d_rst_outs", 32'({o_wr_done, o_wr_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_pix_data}), 32'd0);
    end
    idle();
    @(negedge clk) chk("d_rst_nodone", 32'(o_wr_done), 32'd0);

    // randomized traffic
    act_r = 1'b0; blank_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) act_r = ~act_r;
      if ($urandom_range(0, 99) == 0) blank_r = ~blank_r;
      r = $urandom_range(0, 15);
      if (r == 0)      ra = 15'(19200 + $urandom_range(0, 13567));
      else if (r == 1) ra = 15'd19199;
      else if (r == 2) ra = 15'd19200;
      else             ra = 15'($urandom_range(0, NWORDS - 1));
      drive(0, (k % 4) == 0, act_r, blank_r, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
            1'($urandom_range(0, 1)), ra, 8'($urandom));
    end

    for (int k = 0; k < 12; k++) drive(0, (k % 4) == 0, 0, 0, 10'd3, 10'd3, 0, '0, '0);
    chk("drain_empty", 32'(wq.size() + errq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
